// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared by the ALU op sequencer and its register file.
// Holds the ALU function-select codes, the sequencer state encoding, the
// default datapath width and small helpers for classifying FS codes.
package alu_pkg;

  localparam int ALU_WIDTH = 16;

  // ALU function-select codes. The sequencer only treats shifts, PASS and
  // the reserved codes specially; the other codes pass through to the ALU.
  localparam logic [3:0] FS_ADD  = 4'b0000;
  localparam logic [3:0] FS_SUB  = 4'b0001;
  localparam logic [3:0] FS_AND  = 4'b0010;
  localparam logic [3:0] FS_OR   = 4'b0011;
  localparam logic [3:0] FS_XOR  = 4'b0100;
  localparam logic [3:0] FS_NOT  = 4'b0101;
  localparam logic [3:0] FS_SHL  = 4'b0110;
  localparam logic [3:0] FS_SHR  = 4'b0111;
  localparam logic [3:0] FS_INC  = 4'b1100;
  localparam logic [3:0] FS_DEC  = 4'b1111;
  localparam logic [3:0] FS_PASS = 4'b1011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_EXEC,
    ST_SHIFT_DRV,  // drive the accumulator back onto ALU operand A
    ST_SHIFT_CAP,  // capture the single-bit shift result
    ST_WB
  } state_t;

  function automatic logic is_reserved_fs(input logic [3:0] fs);
    case (fs)
      4'b1000, 4'b1001, 4'b1010, 4'b1101, 4'b1110: return 1'b1;
      default:                                     return 1'b0;
    endcase
  endfunction

  function automatic logic is_shift_fs(input logic [3:0] fs);
    return (fs == FS_SHL) || (fs == FS_SHR);
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: NREG x WIDTH register file with two combinational read ports
// and one synchronous write port. R0 always reads zero; writes to it are
// dropped.
// Ports:
//   clk, rst           clock, asynchronous active-high reset (clears all entries)
//   we, waddr, wdata   write port, sampled on the rising edge
//   raddr_a / rdata_a  read port A (combinational)
//   raddr_b / rdata_b  read port B (combinational)
module alu_regfile #(
  parameter int WIDTH = 16,
  parameter int NREG  = 8,
  parameter int AW    = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_b
);

  logic [WIDTH-1:0] mem [NREG];

  // NOTE: this array is deliberately reset -- a mid-op reset must leave every
  // register at 0, so it is built from flops rather than an inferred RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we && (waddr != '0)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == '0) ? '0 : mem[raddr_a];
  assign rdata_b = (raddr_b == '0) ? '0 : mem[raddr_b];

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: multi-cycle controller for a combinational 16-bit ALU.
// Accepts one op at a time over req_valid/req_ready, reads operands from the
// internal register file, drives registered ALU operands, iterates single-bit
// shifts through the ALU, writes the result back and reports done/zero/err.
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   req_valid / req_ready      request handshake (ready only while idle)
//   req_fs, req_rd, req_rs,    function select, destination and source
//   req_rt, req_shamt          registers, shift count (shift ops only)
//   alu_a, alu_b, alu_fs       registered ALU inputs
//   alu_y                      ALU result (combinational from alu_a/b/fs)
//   done, result, zero         retire pulse, held result, held result==0 flag
//   err                        pulse when a reserved FS is rejected
//   busy                       high whenever not idle
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int NREG  = 8,
  parameter int AW    = $clog2(NREG),
  parameter int SHW   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_fs,
  input  logic [AW-1:0]    req_rd,
  input  logic [AW-1:0]    req_rs,
  input  logic [AW-1:0]    req_rt,
  input  logic [SHW-1:0]   req_shamt,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_fs,
  input  logic [WIDTH-1:0] alu_y,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             err,
  output logic             busy
);

  state_t           state, state_nxt;
  logic [3:0]       fs_q;
  logic [AW-1:0]    rd_q, rs_q, rt_q;
  logic [SHW-1:0]   shamt_q;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] rdata_a, rdata_b;
  logic             accept;

  assign req_ready = (state == ST_IDLE);
  assign busy      = ~req_ready;
  assign accept    = req_valid & req_ready;

  alu_regfile #(
    .WIDTH(WIDTH),
    .NREG (NREG),
    .AW   (AW)
  ) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (state == ST_WB),
    .waddr  (rd_q),
    .wdata  (acc),
    .raddr_a(rs_q),
    .rdata_a(rdata_a),
    .raddr_b(rt_q),
    .rdata_b(rdata_b)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: state_nxt gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (accept && !is_reserved_fs(req_fs)) state_nxt = ST_READ;
      ST_READ:      state_nxt = ST_EXEC;
      // EXEC already performed the first shift; only extra bits iterate.
      ST_EXEC:      state_nxt = (is_shift_fs(fs_q) && (shamt_q > SHW'(1)))
                                ? ST_SHIFT_DRV : ST_WB;
      ST_SHIFT_DRV: state_nxt = ST_SHIFT_CAP;
      ST_SHIFT_CAP: state_nxt = (cnt == SHW'(1)) ? ST_WB : ST_SHIFT_DRV;
      ST_WB:        state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: every register here uses <= so all of them sample the values from
  // before the edge; blocking assignments would let acc/cnt race alu_a.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fs_q    <= FS_ADD;
      rd_q    <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      shamt_q <= '0;
      cnt     <= '0;
      acc     <= '0;
      alu_a   <= '0;
      alu_b   <= '0;
      alu_fs  <= FS_PASS;
      result  <= '0;
      zero    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            fs_q    <= req_fs;
            rd_q    <= req_rd;
            rs_q    <= req_rs;
            rt_q    <= req_rt;
            shamt_q <= req_shamt;
            err     <= is_reserved_fs(req_fs);
          end
        end
        ST_READ: begin
          alu_a  <= rdata_a;
          alu_b  <= rdata_b;
          // A zero-length shift must return A unchanged, so route it as PASS.
          alu_fs <= (is_shift_fs(fs_q) && (shamt_q == '0)) ? FS_PASS : fs_q;
        end
        ST_EXEC: begin
          acc <= alu_y;
          cnt <= shamt_q - SHW'(1);
        end
        ST_SHIFT_DRV: alu_a <= acc;
        ST_SHIFT_CAP: begin
          acc <= alu_y;
          cnt <= cnt - SHW'(1);
        end
        ST_WB: begin
          result <= acc;
          zero   <= (acc == '0);
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_fs;
  logic [2:0]  req_rd, req_rs, req_rt;
  logic [3:0]  req_shamt;
  logic [15:0] alu_a, alu_b, alu_y, result;
  logic [3:0]  alu_fs;
  logic        done, zero, err, busy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0]  fs;
    logic [2:0]  rd, rs, rt;
    logic [3:0]  shamt;
    logic [15:0] res;
    logic        z;
    int          lat;
  } vec_t;

  vec_t tbl[$];
  vec_t sb_q[$];

  always #5 clk = ~clk;

  // Bench-side combinational ALU.
  always_comb begin
    alu_y = '0;
    case (alu_fs)
      FS_ADD:  alu_y = alu_a + alu_b;
      FS_SUB:  alu_y = alu_a - alu_b;
      FS_AND:  alu_y = alu_a & alu_b;
      FS_OR:   alu_y = alu_a | alu_b;
      FS_XOR:  alu_y = alu_a ^ alu_b;
      FS_NOT:  alu_y = ~alu_a;
      FS_SHL:  alu_y = {alu_a[14:0], 1'b0};
      FS_SHR:  alu_y = {1'b0, alu_a[15:1]};
      FS_PASS: alu_y = alu_a;
      FS_INC:  alu_y = alu_a + 16'd1;
      FS_DEC:  alu_y = alu_a - 16'd1;
      default: alu_y = '0;
    endcase
  end

  alu_op_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_fs   (req_fs),
    .req_rd   (req_rd),
    .req_rs   (req_rs),
    .req_rt   (req_rt),
    .req_shamt(req_shamt),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_fs   (alu_fs),
    .alu_y    (alu_y),
    .done     (done),
    .result   (result),
    .zero     (zero),
    .err      (err),
    .busy     (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] fs, input logic [2:0] rd, input logic [2:0] rs,
                              input logic [2:0] rt, input logic [3:0] sh, input logic [15:0] res,
                              input logic z, input int lat);
    vec_t v;
    v.fs = fs; v.rd = rd; v.rs = rs; v.rt = rt; v.shamt = sh;
    v.res = res; v.z = z; v.lat = lat;
    return v;
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"},  req_ready, 1'b1);
    check({tag, "_busy"},   busy,      1'b0);
    check({tag, "_done"},   done,      1'b0);
    check({tag, "_err"},    err,       1'b0);
    check({tag, "_result"}, result,    16'h0000);
    check({tag, "_zero"},   zero,      1'b0);
    check({tag, "_alu_a"},  alu_a,     16'h0000);
    check({tag, "_alu_b"},  alu_b,     16'h0000);
    check({tag, "_alu_fs"}, alu_fs,    4'b1011);
  endtask

  // Called at a negedge; returns at the negedge on which done is seen.
  task automatic issue(input vec_t v);
    int   n;
    bit   got;
    vec_t e;
    got = 0;
    for (int k = 0; k < 50 && !req_ready; k++) @(negedge clk);
    check("ready_before_issue", req_ready, 1'b1);
    req_fs = v.fs; req_rd = v.rd; req_rs = v.rs; req_rt = v.rt; req_shamt = v.shamt;
    req_valid = 1'b1;
    sb_q.push_back(v);
    @(posedge clk);
    n = 1;
    @(negedge clk);
    req_valid = 1'b0;
    check("busy_after_accept", busy, 1'b1);
    for (int k = 0; k < 64; k++) begin
      if (done) begin
        got = 1;
        break;
      end
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    e = sb_q.pop_front();
    if (!got) begin
      check("done_timeout", 1'b0, 1'b1);
    end else begin
      check("result",   result, e.res);
      check("zero",     zero,   e.z);
      check("latency",  n,      e.lat);
      check("err_quiet", err,   1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_cnt;
    rst = 1'b1;
    req_valid = 1'b0;
    req_fs = '0; req_rd = '0; req_rs = '0; req_rt = '0; req_shamt = '0;
    @(negedge clk);
    check_reset_values("reset");
    @(negedge clk);
    rst = 1'b0;

    // fs, rd, rs, rt, shamt, result, zero, latency
    tbl.push_back(mk(FS_INC,  1, 0, 0, 0,  16'h0001, 0, 4));
    tbl.push_back(mk(FS_SHL,  2, 1, 0, 2,  16'h0004, 0, 6));
    tbl.push_back(mk(FS_INC,  1, 2, 0, 0,  16'h0005, 0, 4));
    tbl.push_back(mk(FS_DEC,  2, 1, 0, 0,  16'h0004, 0, 4));
    tbl.push_back(mk(FS_DEC,  2, 2, 0, 0,  16'h0003, 0, 4));
    tbl.push_back(mk(FS_ADD,  3, 1, 2, 0,  16'h0008, 0, 4));
    tbl.push_back(mk(FS_PASS, 0, 3, 0, 0,  16'h0008, 0, 4));
    tbl.push_back(mk(FS_ADD,  2, 1, 0, 0,  16'h0005, 0, 4));
    tbl.push_back(mk(FS_SUB,  4, 1, 2, 0,  16'h0000, 1, 4));
    tbl.push_back(mk(FS_AND,  1, 0, 1, 0,  16'h0000, 1, 4));
    tbl.push_back(mk(FS_INC,  2, 0, 0, 0,  16'h0001, 0, 4));
    tbl.push_back(mk(FS_SUB,  5, 1, 2, 0,  16'hFFFF, 0, 4));
    tbl.push_back(mk(FS_INC,  1, 0, 0, 0,  16'h0001, 0, 4));
    tbl.push_back(mk(FS_SHL,  6, 1, 0, 15, 16'h8000, 0, 32));
    tbl.push_back(mk(FS_SHL,  7, 1, 0, 0,  16'h0001, 0, 4));
    tbl.push_back(mk(FS_SHR,  7, 6, 0, 3,  16'h1000, 0, 8));
    tbl.push_back(mk(FS_ADD,  0, 1, 1, 0,  16'h0002, 0, 4));
    tbl.push_back(mk(FS_PASS, 7, 0, 0, 0,  16'h0000, 1, 4));
    tbl.push_back(mk(FS_OR,   7, 6, 1, 0,  16'h8001, 0, 4));
    tbl.push_back(mk(FS_XOR,  7, 7, 6, 0,  16'h0001, 0, 4));
    tbl.push_back(mk(FS_NOT,  4, 0, 0, 0,  16'hFFFF, 0, 4));
    tbl.push_back(mk(FS_SHR,  4, 4, 0, 1,  16'h7FFF, 0, 4));
    tbl.push_back(mk(FS_ADD,  0, 1, 1, 7,  16'h0002, 0, 4));

    foreach (tbl[i]) issue(tbl[i]);

    // Reserved FS: one-cycle err, no done, no write to R3, ready stays up.
    req_fs = 4'b1000; req_rd = 3; req_rs = 1; req_rt = 2; req_shamt = 0;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("err_pulse",      err,       1'b1);
    check("err_no_done",    done,      1'b0);
    check("err_ready",      req_ready, 1'b1);
    check("err_not_busy",   busy,      1'b0);
    @(negedge clk);
    check("err_pulse_end",  err,       1'b0);
    check("err_no_done2",   done,      1'b0);
    issue(mk(FS_PASS, 0, 3, 0, 0, 16'h0008, 0, 4));

    // Reset in the middle of an 8-bit shift.
    req_fs = FS_SHL; req_rd = 5; req_rs = 1; req_rt = 0; req_shamt = 8;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("midshift_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    check_reset_values("midop_reset");
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("no_done_after_reset", done_cnt, 0);
    issue(mk(FS_PASS, 0, 1, 0, 0, 16'h0000, 1, 4));
    issue(mk(FS_PASS, 0, 3, 0, 0, 16'h0000, 1, 4));
    issue(mk(FS_ADD,  0, 6, 4, 0, 16'h0000, 1, 4));

    check("scoreboard_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
